adder_tree: RTL and testbench

Parametrised, pipelined N-operand adder with full bit growth, optional two's-complement mode and a valid sideband. It is the multi-operand, signed-capable successor to the two-input registered unsigned adder in the DSP primitives library. It serves as the summation back-end for FIR taps, beamformer channel sums and moving-sum blocks. It accepts one operand vector per clock and produces one full-precision sum per clock after a fixed latency.

---
 rtl/dspbb_pkg.sv | 26 ++
 rtl/adder_tree_level.sv | 60 ++++++
 rtl/adder_tree.sv | 61 ++++++
 tb/tb_adder_tree.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dspbb_pkg.sv
// rtl/dspbb_pkg.sv - shared DSP building-block constants and width helpers
package dspbb_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Full-precision width of a sum of ninputs operands of iwidth bits each.
    function automatic int sum_width(input int iwidth, input int ninputs);
        return iwidth + clog2(ninputs);
    endfunction

    // Number of partial sums held by tree level `level` (level 0 = raw operands).
    function automatic int level_count(input int ninputs, input int level);
        return (ninputs + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise-add level of the adder tree
module adder_tree_level #(
    parameter int NIN    = 4,
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_valid,
    input  logic [NIN*WIDTH-1:0]                  i_data,
    output logic                                  o_valid,
    output logic [((NIN+1)/2)*(WIDTH+1)-1:0]      o_data
);

    localparam int NOUT = (NIN + 1) / 2;
    localparam int OW   = WIDTH + 1;
    // An odd operand count is padded with one zero operand so every output
    // is a plain pair sum; the zero extends to zero in either signedness.
    localparam int NPAD = 2 * NOUT;

    logic [NPAD*WIDTH-1:0] padded;
    logic                  valid_d;
    logic                  valid_q;
    logic [NOUT*OW-1:0]    sum_d;
    logic [NOUT*OW-1:0]    sum_q;

    assign padded = (NPAD*WIDTH)'(i_data);

    // One guard bit per level makes overflow impossible in both modes.
    function automatic logic [OW-1:0] extend(input logic [WIDTH-1:0] x);
        return {(SIGNED != 0) ? x[WIDTH-1] : 1'b0, x};
    endfunction

    // Pair sums load only with a valid vector so the last valid result is held.
    always_comb begin
        valid_d = i_valid;
        sum_d   = sum_q;
        if (i_valid) begin
            for (int j = 0; j < NOUT; j++) begin
                sum_d[j*OW +: OW] = extend(padded[(2*j)*WIDTH +: WIDTH])
                                  + extend(padded[(2*j+1)*WIDTH +: WIDTH]);
            end
        end
    end

    // Level registers; reset clears in-flight data and flags immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = sum_q;

endmodule

// File: rtl/adder_tree.sv
// rtl/adder_tree.sv - pipelined N-operand full-precision adder tree
module adder_tree
    import dspbb_pkg::*;
#(
    parameter int NINPUTS = 4,
    parameter int IWIDTH  = 16,
    parameter int SIGNED  = 0,
    localparam int STAGES = clog2(NINPUTS),
    localparam int OWIDTH = sum_width(IWIDTH, NINPUTS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [NINPUTS*IWIDTH-1:0] i_data,
    output logic                      o_valid,
    output logic [OWIDTH-1:0]         o_sum
);

    if (NINPUTS < 2 || NINPUTS > 64 || IWIDTH < 1 || IWIDTH > 32 ||
        (SIGNED != 0 && SIGNED != 1)) begin : g_param_check
        $error("adder_tree: parameter out of range");
    end

    // Level l consumes ceil(NINPUTS/2^l) operands of IWIDTH+l bits and
    // produces half as many (rounded up) sums one bit wider.
    for (genvar l = 0; l < STAGES; l++) begin : g_level
        localparam int NIN_L  = level_count(NINPUTS, l);
        localparam int NOUT_L = level_count(NINPUTS, l + 1);
        localparam int W_L    = IWIDTH + l;

        logic [NIN_L*W_L-1:0]        lvl_data;
        logic                        lvl_valid;
        logic [NOUT_L*(W_L+1)-1:0]   sum;
        logic                        sum_valid;

        if (l == 0) begin : g_first
            assign lvl_data  = i_data;
            assign lvl_valid = i_valid;
        end else begin : g_next
            assign lvl_data  = g_level[l-1].sum;
            assign lvl_valid = g_level[l-1].sum_valid;
        end

        adder_tree_level #(
            .NIN    (NIN_L),
            .WIDTH  (W_L),
            .SIGNED (SIGNED)
        ) u_level (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_valid (lvl_valid),
            .i_data  (lvl_data),
            .o_valid (sum_valid),
            .o_data  (sum)
        );
    end

    assign o_valid = g_level[STAGES-1].sum_valid;
    assign o_sum   = g_level[STAGES-1].sum;

endmodule

// File: tb/tb_adder_tree.sv
// tb/tb_adder_tree.sv - randomized and directed bench for adder_tree
module tb_adder_tree;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;

    logic        ov0, ov1, ov2, ov3;
    logic [17:0] os0, os1;
    logic [10:0] os2;
    logic [1:0]  os3;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int n          = 0;
    int first_idx  = 0;

    // instance descriptions: 4x16 unsigned, 4x16 signed, 5x8 unsigned, 2x1 unsigned
    int st  [4] = '{2, 2, 3, 1};
    int ow  [4] = '{18, 18, 11, 2};
    int nin [4] = '{4, 4, 5, 2};
    int iw  [4] = '{16, 16, 8, 1};
    int sg  [4] = '{0, 1, 0, 0};

    logic        hist_v [0:2047];
    logic [63:0] hist_d [0:2047];

    adder_tree #(.NINPUTS(4), .IWIDTH(16), .SIGNED(0)) u_uns (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data),
        .o_valid(ov0), .o_sum(os0));
    adder_tree #(.NINPUTS(4), .IWIDTH(16), .SIGNED(1)) u_sgn (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data),
        .o_valid(ov1), .o_sum(os1));
    adder_tree #(.NINPUTS(5), .IWIDTH(8), .SIGNED(0)) u_odd (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data[39:0]),
        .o_valid(ov2), .o_sum(os2));
    adder_tree #(.NINPUTS(2), .IWIDTH(1), .SIGNED(0)) u_min (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_data(in_data[1:0]),
        .o_valid(ov3), .o_sum(os3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Mathematical sum of the operands of instance inst packed in d.
    function automatic longint model_sum(input int inst, input logic [63:0] d);
        longint s;
        longint v;
        int     w;
        s = 0;
        w = iw[inst];
        for (int k = 0; k < nin[inst]; k++) begin
            v = longint'((d >> (k * w)) & ((64'd1 << w) - 64'd1));
            if (sg[inst] != 0 && v[w-1]) v = v - (longint'(1) << w);
            s = s + v;
        end
        return s;
    endfunction

    // One clock: check all outputs against the model at the falling edge, then drive.
    task automatic tick(input logic v, input logic [63:0] d);
        logic [63:0] act_s [4];
        logic [3:0]  act_v;
        logic        ev;
        logic [63:0] es;
        int          idx;
        @(negedge clk);
        act_v    = {ov3, ov2, ov1, ov0};
        act_s[0] = 64'(os0);
        act_s[1] = 64'(os1);
        act_s[2] = 64'(os2);
        act_s[3] = 64'(os3);
        for (int i = 0; i < 4; i++) begin
            idx = n - st[i];
            ev  = 1'b0;
            es  = '0;
            if (idx >= first_idx) ev = hist_v[idx];
            for (int k = idx; k >= first_idx; k--) begin
                if (hist_v[k]) begin
                    es = 64'(model_sum(i, hist_d[k])) & ((64'd1 << ow[i]) - 64'd1);
                    break;
                end
            end
            assert_cnt++;
            if (act_v[i] !== ev || act_s[i] !== es) begin
                fail_cnt++;
                $display("FAIL model_inst%0d cycle %0d: got valid=%b sum=%h, expected valid=%b sum=%h",
                         i, n, act_v[i], act_s[i], ev, es);
            end
        end
        if (rst) rst = 1'b0;
        hist_v[n] = v;
        hist_d[n] = d;
        in_valid  = v;
        in_data   = d;
        n++;
    endtask

    task automatic test_reset();
        #1;
        assert_cnt++;
        if ({ov3, ov2, ov1, ov0} !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL reset_valid: got %b expected 0000", {ov3, ov2, ov1, ov0});
        end
        assert_cnt++;
        if ({os0, os1, os2, os3} !== 49'd0) begin
            fail_cnt++;
            $display("FAIL reset_sum: got %h %h %h %h expected all 0", os0, os1, os2, os3);
        end
        tick(1'b0, 64'd0);
    endtask

    task automatic test_unsigned_max();
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov0 !== 1'b0) begin
            fail_cnt++;
            $display("FAIL umax_early: got valid=%b expected 0", ov0);
        end
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov0 !== 1'b1 || os0 !== 18'h3FFFC) begin
            fail_cnt++;
            $display("FAIL umax_sum: got valid=%b sum=%h expected 1 3fffc", ov0, os0);
        end
        assert_cnt++;
        if (os1 !== 18'h3FFFC) begin
            fail_cnt++;
            $display("FAIL umax_signed_minus4: got %h expected 3fffc", os1);
        end
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov0 !== 1'b0 || os0 !== 18'h3FFFC) begin
            fail_cnt++;
            $display("FAIL umax_hold: got valid=%b sum=%h expected 0 3fffc", ov0, os0);
        end
    endtask

    task automatic test_signed_extreme();
        tick(1'b1, 64'h8000_8000_8000_8000);
        tick(1'b1, 64'hFFF6_0005_FFFF_7FFF);
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov1 !== 1'b1 || os1 !== 18'h20000) begin
            fail_cnt++;
            $display("FAIL signed_min: got valid=%b sum=%h expected 1 20000", ov1, os1);
        end
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov1 !== 1'b1 || os1 !== 18'h07FF9) begin
            fail_cnt++;
            $display("FAIL signed_mixed: got valid=%b sum=%h expected 1 07ff9", ov1, os1);
        end
    endtask

    task automatic test_odd_count();
        tick(1'b1, 64'h0000_00FA_0403_0201);
        tick(1'b0, rnd64());
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov2 !== 1'b0) begin
            fail_cnt++;
            $display("FAIL odd_early: got valid=%b expected 0", ov2);
        end
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov2 !== 1'b1 || os2 !== 11'd260) begin
            fail_cnt++;
            $display("FAIL odd_sum: got valid=%b sum=%0d expected 1 260", ov2, os2);
        end
    endtask

    task automatic test_min_config();
        tick(1'b1, 64'h3);
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov3 !== 1'b1 || os3 !== 2'b10) begin
            fail_cnt++;
            $display("FAIL min_sum: got valid=%b sum=%b expected 1 10", ov3, os3);
        end
    endtask

    task automatic test_bubbles();
        logic [63:0] vec [6];
        logic        vv  [6];
        logic        exp_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int          exp_s [4] = '{10, 20, 20, 30};
        logic        obs_v [6];
        logic [17:0] obs_s [6];
        vec[0] = 64'h0004_0003_0002_0001; vv[0] = 1'b1;
        vec[1] = 64'h0005_0005_0005_0005; vv[1] = 1'b1;
        vec[2] = rnd64();                 vv[2] = 1'b0;
        vec[3] = 64'h0005_0005_000A_000A; vv[3] = 1'b1;
        vec[4] = rnd64();                 vv[4] = 1'b0;
        vec[5] = rnd64();                 vv[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(vv[k], vec[k]);
            obs_v[k] = ov0;
            obs_s[k] = os0;
        end
        for (int k = 0; k < 4; k++) begin
            assert_cnt++;
            if (obs_v[k+2] !== exp_v[k] || obs_s[k+2] !== 18'(exp_s[k])) begin
                fail_cnt++;
                $display("FAIL bubble_%0d: got valid=%b sum=%0d expected %b %0d",
                         k, obs_v[k+2], obs_s[k+2], exp_v[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, rnd64());
        tick(1'b1, rnd64());
        tick(1'b0, rnd64());
        #3;
        rst       = 1'b1;
        first_idx = n;
        #1;
        assert_cnt++;
        if ({ov3, ov2, ov1, ov0} !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL midreset_valid: got %b expected 0000", {ov3, ov2, ov1, ov0});
        end
        assert_cnt++;
        if ({os0, os1, os2, os3} !== 49'd0) begin
            fail_cnt++;
            $display("FAIL midreset_sum: got %h %h %h %h expected all 0", os0, os1, os2, os3);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, rnd64());
        tick(1'b1, 64'h0000_0032_281E_140A);
        tick(1'b0, rnd64());
        tick(1'b0, rnd64());
        tick(1'b0, rnd64());
        assert_cnt++;
        if (ov2 !== 1'b1 || os2 !== 11'd150) begin
            fail_cnt++;
            $display("FAIL midreset_next: got valid=%b sum=%0d expected 1 150", ov2, os2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 150; k++) tick($urandom_range(0, 3) != 0, rnd64());
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) tick(1'b1, rnd64());
        for (int k = 0; k < 4; k++) tick(1'b0, rnd64());
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_unsigned_max();
        test_signed_extreme();
        test_odd_count();
        test_min_config();
        test_bubbles();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
